// File: rtl/sr_flag_scheduler_if.sv
// Requester/bank-side signal bundle for sr_flag_scheduler.
// The master drives commands; the slave (the scheduler) answers with grants, pulses and shadow state.
interface sr_flag_scheduler_if #(
  parameter int NREQ   = 4,
  parameter int NFLAGS = 8,
  parameter int IDXW   = 3
);
  logic [NREQ-1:0]      req;
  logic [NREQ-1:0]      op;
  logic [NREQ*IDXW-1:0] idx;
  logic [NREQ-1:0]      gnt;
  logic [NFLAGS-1:0]    s_out;
  logic [NFLAGS-1:0]    r_out;
  logic [NFLAGS-1:0]    flags;
  logic                 busy;
  logic                 err;

  modport master (
    output req, op, idx,
    input  gnt, s_out, r_out, flags, busy, err
  );

  modport slave (
    input  req, op, idx,
    output gnt, s_out, r_out, flags, busy, err
  );
endinterface

// File: rtl/sr_flag_scheduler.sv
// Round-robin scheduler serialising set/clear commands onto an SR flip-flop bank.
// Each command takes DRIVE + GAP, so S and R are never high together and pulses are always separated.
module sr_flag_scheduler #(
  parameter int NREQ   = 4,
  parameter int NFLAGS = 8,
  parameter int IDXW   = 3
) (
  input  logic               clk,
  input  logic               rst,
  sr_flag_scheduler_if.slave bus
);

  localparam int PW = (NREQ > 1) ? $clog2(NREQ) : 1;

  typedef enum logic [1:0] {
    IDLE,
    DRIVE,
    GAP
  } state_t;

  state_t            state_q, state_d;
  logic [PW-1:0]     ptr_q, ptr_d;
  logic [NREQ-1:0]   gnt_q, gnt_d;
  logic [NFLAGS-1:0] s_q, s_d;
  logic [NFLAGS-1:0] r_q, r_d;
  logic [NFLAGS-1:0] flags_q, flags_d;
  logic              busy_q, busy_d;
  logic              err_q, err_d;

  // Latched command: the mask is empty for an out-of-range index, so the flag update is a no-op.
  logic              cmd_op_q, cmd_op_d;
  logic [NFLAGS-1:0] cmd_mask_q, cmd_mask_d;
  logic [PW-1:0]     cmd_w_q, cmd_w_d;

  logic [IDXW-1:0]   idx_arr [NREQ];
  logic              found;
  logic [PW-1:0]     win;
  logic              sel_op;
  logic [IDXW-1:0]   sel_idx;
  logic              in_range;
  logic [NFLAGS-1:0] sel_mask;

  for (genvar g = 0; g < NREQ; g++) begin : g_split
    assign idx_arr[g] = bus.idx[g*IDXW +: IDXW];
  end

  // First requesting index at or after ptr, wrapping.
  always_comb begin
    int unsigned   pos;
    logic [PW-1:0] posb;
    found = 1'b0;
    win   = '0;
    pos   = 0;
    posb  = '0;
    for (int unsigned k = 0; k < NREQ; k++) begin
      pos  = (32'(ptr_q) + k) % NREQ;
      posb = PW'(pos);
      if (!found && bus.req[posb]) begin
        found = 1'b1;
        win   = posb;
      end
    end
  end

  always_comb begin
    sel_op   = bus.op[win];
    sel_idx  = idx_arr[win];
    in_range = 32'(sel_idx) < NFLAGS;
    sel_mask = in_range ? (NFLAGS'(1) << sel_idx) : '0;
  end

  always_comb begin
    state_d    = state_q;
    ptr_d      = ptr_q;
    gnt_d      = '0;
    s_d        = '0;
    r_d        = '0;
    flags_d    = flags_q;
    busy_d     = 1'b0;
    err_d      = 1'b0;
    cmd_op_d   = cmd_op_q;
    cmd_mask_d = cmd_mask_q;
    cmd_w_d    = cmd_w_q;
    unique case (state_q)
      IDLE: begin
        if (found) begin
          gnt_d      = NREQ'(1) << win;
          busy_d     = 1'b1;
          err_d      = !in_range;
          cmd_op_d   = sel_op;
          cmd_mask_d = sel_mask;
          cmd_w_d    = win;
          if (sel_op) s_d = sel_mask;
          else        r_d = sel_mask;
          state_d    = DRIVE;
        end
      end
      DRIVE: begin
        flags_d = cmd_op_q ? (flags_q | cmd_mask_q) : (flags_q & ~cmd_mask_q);
        ptr_d   = (32'(cmd_w_q) == NREQ - 1) ? '0 : cmd_w_q + PW'(1);
        busy_d  = 1'b1;
        state_d = GAP;
      end
      GAP: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= IDLE;
      ptr_q      <= '0;
      gnt_q      <= '0;
      s_q        <= '0;
      r_q        <= '0;
      flags_q    <= '0;
      busy_q     <= 1'b0;
      err_q      <= 1'b0;
      cmd_op_q   <= 1'b0;
      cmd_mask_q <= '0;
      cmd_w_q    <= '0;
    end else begin
      state_q    <= state_d;
      ptr_q      <= ptr_d;
      gnt_q      <= gnt_d;
      s_q        <= s_d;
      r_q        <= r_d;
      flags_q    <= flags_d;
      busy_q     <= busy_d;
      err_q      <= err_d;
      cmd_op_q   <= cmd_op_d;
      cmd_mask_q <= cmd_mask_d;
      cmd_w_q    <= cmd_w_d;
    end
  end

  assign bus.gnt   = gnt_q;
  assign bus.s_out = s_q;
  assign bus.r_out = r_q;
  assign bus.flags = flags_q;
  assign bus.busy  = busy_q;
  assign bus.err   = err_q;

endmodule

// File: tb/tb_sr_flag_scheduler.sv
// Self-checking bench for sr_flag_scheduler: directed scenarios plus random load,
// all compared against an edge-counting reference model of the command schedule.
module tb_sr_flag_scheduler;

  localparam int NREQ   = 4;
  localparam int NFLAGS = 6;
  localparam int IDXW   = 3;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  sr_flag_scheduler_if #(.NREQ(NREQ), .NFLAGS(NFLAGS), .IDXW(IDXW)) bus ();

  sr_flag_scheduler #(.NREQ(NREQ), .NFLAGS(NFLAGS), .IDXW(IDXW)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  logic [NREQ-1:0]      req_r = '0;
  logic [NREQ-1:0]      op_r  = '0;
  logic [NREQ*IDXW-1:0] idx_r = '0;

  assign bus.req = req_r;
  assign bus.op  = op_r;
  assign bus.idx = idx_r;

  int n_checks = 0;
  int n_fail   = 0;

  // Reference model: a command accepted at edge A is driven during A..A+1,
  // lands in flags at A+1, and the next acceptance is possible at A+3.
  int                edge_n   = 0;
  int                acc_edge = -100;
  int                m_ptr    = 0;
  int                m_w      = 0;
  int                m_idx    = 0;
  bit                m_op     = 1'b0;
  logic [NFLAGS-1:0] m_flags  = '0;
  bit                rand_en  = 1'b0;
  int                grant_log[$];

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic set_cmd(input int i, input bit o, input int ix);
    req_r[i]                = 1'b1;
    op_r[i]                 = o;
    idx_r[i*IDXW +: IDXW]   = IDXW'(ix);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    #1;
    check_eq("rst_gnt",   32'(bus.gnt),   0);
    check_eq("rst_s",     32'(bus.s_out), 0);
    check_eq("rst_r",     32'(bus.r_out), 0);
    check_eq("rst_flags", 32'(bus.flags), 0);
    check_eq("rst_busy",  32'(bus.busy),  0);
    check_eq("rst_err",   32'(bus.err),   0);
    req_r = '0;
    op_r  = '0;
    idx_r = '0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst      = 1'b0;
    m_flags  = '0;
    m_ptr    = 0;
    acc_edge = edge_n - 100;
  endtask

  task automatic step();
    int                d;
    logic [NREQ-1:0]   eg;
    logic [NFLAGS-1:0] es, er;
    bit                ee, eb;
    @(posedge clk);
    edge_n++;
    if (edge_n - acc_edge >= 3 && req_r != '0) begin
      for (int k = 0; k < NREQ; k++) begin
        int j = (m_ptr + k) % NREQ;
        if (req_r[j]) begin
          m_w = j;
          break;
        end
      end
      m_op     = op_r[m_w];
      m_idx    = int'(idx_r[m_w*IDXW +: IDXW]);
      acc_edge = edge_n;
      grant_log.push_back(m_w);
    end else if (edge_n - acc_edge == 1) begin
      if (m_idx < NFLAGS) m_flags[m_idx] = m_op;
      m_ptr = (m_w + 1) % NREQ;
    end
    d  = edge_n - acc_edge;
    eg = '0; es = '0; er = '0; ee = 1'b0; eb = 1'b0;
    if (d == 0) begin
      eg[m_w] = 1'b1;
      eb      = 1'b1;
      if (m_idx < NFLAGS) begin
        if (m_op) es[m_idx] = 1'b1;
        else      er[m_idx] = 1'b1;
      end else begin
        ee = 1'b1;
      end
    end else if (d == 1) begin
      eb = 1'b1;
    end
    #1;
    if (d == 1) req_r[m_w] = 1'b0;
    if (rand_en) begin
      for (int i = 0; i < NREQ; i++) begin
        if (!req_r[i] && !(d == 1 && i == m_w) && $urandom_range(0, 3) == 0)
          set_cmd(i, 1'($urandom_range(0, 1)), int'($urandom_range(0, 7)));
      end
    end
    @(negedge clk);
    check_eq("gnt",   32'(bus.gnt),   32'(eg));
    check_eq("s_out", 32'(bus.s_out), 32'(es));
    check_eq("r_out", 32'(bus.r_out), 32'(er));
    check_eq("flags", 32'(bus.flags), 32'(m_flags));
    check_eq("busy",  32'(bus.busy),  32'(eb));
    check_eq("err",   32'(bus.err),   32'(ee));
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    do_reset();

    // Basic set on requester 2
    set_cmd(2, 1'b1, 5);
    step();
    check_eq("t1_gnt", 32'(bus.gnt), 32'h4);
    check_eq("t1_s", 32'(bus.s_out), 32'h20);
    step();
    check_eq("t1_flags", 32'(bus.flags), 32'h20);
    check_eq("t1_busy_gap", 32'(bus.busy), 1);
    step();
    check_eq("t1_busy_idle", 32'(bus.busy), 0);

    // Round robin, two full rounds
    do_reset();
    grant_log.delete();
    for (int i = 0; i < NREQ; i++) set_cmd(i, 1'($urandom_range(0, 1)), int'($urandom_range(0, 5)));
    repeat (12) step();
    for (int i = 0; i < NREQ; i++) set_cmd(i, 1'($urandom_range(0, 1)), int'($urandom_range(0, 5)));
    repeat (12) step();
    check_eq("rr_count", 32'(grant_log.size()), 8);
    for (int k = 0; k < grant_log.size() && k < 8; k++) check_eq("rr_order", 32'(grant_log[k]), 32'(k % NREQ));

    // Conflicting set/clear on the same flag
    do_reset();
    set_cmd(0, 1'b1, 3);
    set_cmd(1, 1'b0, 3);
    step();
    check_eq("cf_s", 32'(bus.s_out), 32'h08);
    check_eq("cf_gnt0", 32'(bus.gnt), 32'h1);
    step();
    check_eq("cf_flags_set", 32'(bus.flags), 32'h08);
    step();
    step();
    check_eq("cf_r", 32'(bus.r_out), 32'h08);
    check_eq("cf_gnt1", 32'(bus.gnt), 32'h2);
    step();
    check_eq("cf_flags_clr", 32'(bus.flags), 32'h00);

    // Out-of-range indices
    do_reset();
    set_cmd(3, 1'b1, 7);
    step();
    check_eq("oor_err", 32'(bus.err), 1);
    check_eq("oor_gnt", 32'(bus.gnt), 32'h8);
    check_eq("oor_s", 32'(bus.s_out), 0);
    step();
    check_eq("oor_err_gone", 32'(bus.err), 0);
    check_eq("oor_flags", 32'(bus.flags), 0);
    step();
    set_cmd(0, 1'b1, 6);
    repeat (3) step();

    // Reset in the middle of DRIVE
    do_reset();
    set_cmd(1, 1'b1, 1);
    step();
    check_eq("md_s_before", 32'(bus.s_out), 32'h02);
    do_reset();
    set_cmd(1, 1'b1, 2);
    set_cmd(0, 1'b1, 0);
    step();
    check_eq("md_ptr0", 32'(bus.gnt), 32'h1);
    repeat (5) step();

    // Redundant set of flag 0
    do_reset();
    set_cmd(0, 1'b1, 0);
    step();
    check_eq("rd_s1", 32'(bus.s_out), 32'h01);
    step();
    check_eq("rd_flags1", 32'(bus.flags), 32'h01);
    step();
    check_eq("rd_gap_s", 32'(bus.s_out), 0);
    set_cmd(0, 1'b1, 0);
    step();
    check_eq("rd_s2", 32'(bus.s_out), 32'h01);
    check_eq("rd_flags2", 32'(bus.flags), 32'h01);
    repeat (2) step();

    // Random load
    do_reset();
    rand_en = 1'b1;
    repeat (3000) step();
    rand_en = 1'b0;
    repeat (8) step();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
